// File: rtl/balls_pkg.sv
// Shared types for the ball speed datapath (calculator, speed register, position movers).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package balls_pkg;
    localparam int NUM_BALLS       = 3;
    localparam int SPEED_W         = 11;
    localparam int MAX_SPEED       = 511;
    localparam int FRICTION_PERIOD = 8;
    localparam int FRICTION_STEP   = 1;
    localparam int HOLDOFF_FRAMES  = 4;
    localparam int HOLD_W          = $clog2(HOLDOFF_FRAMES + 1);

    typedef logic [3:0]                ball_id_t;
    typedef logic signed [SPEED_W-1:0] speed_t;
    typedef speed_t [NUM_BALLS-1:0]    speed_vec_t;
    typedef logic [HOLD_W-1:0]         hold_t;
    typedef logic [7:0]                fric_cnt_t;

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_APPLY    = 2'd1,
        ST_FRICTION = 2'd2
    } state_t;
endpackage

// File: rtl/speed_sat_decay.sv
// Per-component speed helper: optional negate, saturate to +/-MAX_SPEED, optional step toward zero.
// Latency: combinational.
// Backpressure: none.
module speed_sat_decay
    import balls_pkg::*;
(
    input  speed_t speed_i,
    input  logic   negate_i,
    input  logic   decay_i,
    output speed_t speed_o
);
    // One extra bit so that negating the most negative code cannot overflow.
    localparam int EXT_W = SPEED_W + 1;
    typedef logic signed [EXT_W-1:0] ext_t;
    localparam ext_t MAX_P = ext_t'(MAX_SPEED);
    localparam ext_t MAX_N = -ext_t'(MAX_SPEED);
    localparam ext_t STEP  = ext_t'(FRICTION_STEP);

    ext_t ext_v;
    ext_t neg_v;
    ext_t sat_v;
    ext_t dec_v;

    always_comb begin
        ext_v = ext_t'(speed_i);
        neg_v = negate_i ? -ext_v : ext_v;
        if (neg_v > MAX_P) begin
            sat_v = MAX_P;
        end else if (neg_v < MAX_N) begin
            sat_v = MAX_N;
        end else begin
            sat_v = neg_v;
        end
        dec_v = sat_v;
        if (decay_i) begin
            if (sat_v > STEP) begin
                dec_v = sat_v - STEP;
            end else if (sat_v < -STEP) begin
                dec_v = sat_v + STEP;
            end else begin
                dec_v = '0;
            end
        end
        speed_o = speed_t'(dec_v);
    end
endmodule

// File: rtl/balls_speed_register.sv
// Authoritative per-ball X/Y speed: collects cue/collision/wall events during a frame, commits on startOfFrame.
// Latency: new speeds visible 1 cycle after the startOfFrame cycle, post-friction final after 2.
// Backpressure: none; a second distinct collision pair in a frame is discarded and flagged.
module balls_speed_register
    import balls_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 collide_valid,
    input  ball_id_t [1:0]       col_id,
    input  speed_vec_t           Xspeed_calc_in,
    input  speed_vec_t           Yspeed_calc_in,
    input  logic                 cue_valid,
    input  ball_id_t             cue_id,
    input  speed_t               cue_Xspeed,
    input  speed_t               cue_Yspeed,
    input  logic [NUM_BALLS-1:0] wall_bounce_x,
    input  logic [NUM_BALLS-1:0] wall_bounce_y,
    output speed_vec_t           Xspeed_VEC_out,
    output speed_vec_t           Yspeed_VEC_out,
    output logic                 all_stopped,
    output logic                 collision_dropped
);
    state_t               state_q, state_d;
    speed_vec_t           x_q, x_d, y_q, y_d;
    logic                 stopped_q, stopped_d, dropped_q, dropped_d;
    logic                 col_seen_q, col_seen_d, col_pend_q, col_pend_d;
    ball_id_t [1:0]       col_id_q, col_id_d;
    speed_t [1:0]         col_x_q, col_x_d, col_y_q, col_y_d;
    logic                 cue_pend_q, cue_pend_d;
    ball_id_t             cue_id_q, cue_id_d;
    speed_t               cue_x_q, cue_x_d, cue_y_q, cue_y_d;
    logic [NUM_BALLS-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    hold_t [NUM_BALLS-1:0] hold_q, hold_d;
    fric_cnt_t            fric_q, fric_d;

    speed_vec_t           sel_x, sel_y, sat_x, sat_y;
    logic [NUM_BALLS-1:0] neg_x, neg_y;
    logic                 decay;
    logic                 ids_ok, hold_clear;
    speed_t [1:0]         cap_x, cap_y;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT:  if (startOfFrame) state_d = ST_APPLY;
            ST_APPLY:    state_d = ST_FRICTION;
            ST_FRICTION: state_d = ST_COLLECT;
            default:     state_d = ST_COLLECT;
        endcase
    end

    // Calculator speeds at the offered pair, and whether either ball is still in holdoff.
    always_comb begin
        ids_ok     = (col_id[0] < ball_id_t'(NUM_BALLS)) && (col_id[1] < ball_id_t'(NUM_BALLS));
        hold_clear = 1'b1;
        cap_x      = '0;
        cap_y      = '0;
        for (int b = 0; b < NUM_BALLS; b++) begin
            for (int k = 0; k < 2; k++) begin
                if (col_id[k] == ball_id_t'(b)) begin
                    cap_x[k] = Xspeed_calc_in[b];
                    cap_y[k] = Yspeed_calc_in[b];
                    if (hold_q[b] != '0) hold_clear = 1'b0;
                end
            end
        end
    end

    always_comb begin
        col_seen_d = col_seen_q;
        col_pend_d = col_pend_q;
        col_id_d   = col_id_q;
        col_x_d    = col_x_q;
        col_y_d    = col_y_q;
        cue_pend_d = cue_pend_q;
        cue_id_d   = cue_id_q;
        cue_x_d    = cue_x_q;
        cue_y_d    = cue_y_q;
        wall_x_d   = wall_x_q;
        wall_y_d   = wall_y_q;
        hold_d     = hold_q;
        fric_d     = fric_q;
        dropped_d  = 1'b0;
        sel_x      = x_q;
        sel_y      = y_q;
        neg_x      = '0;
        neg_y      = '0;
        decay      = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (collide_valid) begin
                    if (!col_seen_q) begin
                        col_seen_d = 1'b1;
                        col_id_d   = col_id;
                        if (ids_ok && hold_clear) begin
                            col_pend_d = 1'b1;
                            col_x_d    = cap_x;
                            col_y_d    = cap_y;
                        end
                    end else if (col_id != col_id_q) begin
                        dropped_d = 1'b1;
                    end
                end
                if (cue_valid && (cue_id < ball_id_t'(NUM_BALLS))) begin
                    cue_pend_d = 1'b1;
                    cue_id_d   = cue_id;
                    cue_x_d    = cue_Xspeed;
                    cue_y_d    = cue_Yspeed;
                end
                wall_x_d = wall_x_q | wall_bounce_x;
                wall_y_d = wall_y_q | wall_bounce_y;
            end
            ST_APPLY: begin
                for (int b = 0; b < NUM_BALLS; b++) begin
                    if (cue_pend_q && (cue_id_q == ball_id_t'(b))) begin
                        sel_x[b] = cue_x_q;
                        sel_y[b] = cue_y_q;
                    end else if (col_pend_q && (col_id_q[0] == ball_id_t'(b))) begin
                        sel_x[b]  = col_x_q[0];
                        sel_y[b]  = col_y_q[0];
                        hold_d[b] = hold_t'(HOLDOFF_FRAMES);
                    end else if (col_pend_q && (col_id_q[1] == ball_id_t'(b))) begin
                        sel_x[b]  = col_x_q[1];
                        sel_y[b]  = col_y_q[1];
                        hold_d[b] = hold_t'(HOLDOFF_FRAMES);
                    end else begin
                        neg_x[b] = wall_x_q[b];
                        neg_y[b] = wall_y_q[b];
                    end
                end
                col_seen_d = 1'b0;
                col_pend_d = 1'b0;
                cue_pend_d = 1'b0;
                wall_x_d   = '0;
                wall_y_d   = '0;
            end
            ST_FRICTION: begin
                for (int b = 0; b < NUM_BALLS; b++) begin
                    if (hold_q[b] != '0) hold_d[b] = hold_q[b] - hold_t'(1);
                end
                decay  = (fric_q == fric_cnt_t'(FRICTION_PERIOD - 1));
                fric_d = decay ? '0 : fric_q + fric_cnt_t'(1);
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        speed_sat_decay u_x (.speed_i(sel_x[g]), .negate_i(neg_x[g]), .decay_i(decay), .speed_o(sat_x[g]));
        speed_sat_decay u_y (.speed_i(sel_y[g]), .negate_i(neg_y[g]), .decay_i(decay), .speed_o(sat_y[g]));
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        stopped_d = stopped_q;
        if ((state_q == ST_APPLY) || (state_q == ST_FRICTION)) begin
            x_d       = sat_x;
            y_d       = sat_y;
            stopped_d = (sat_x == '0) && (sat_y == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            stopped_q  <= 1'b1;
            dropped_q  <= 1'b0;
            col_seen_q <= 1'b0;
            col_pend_q <= 1'b0;
            col_id_q   <= '0;
            col_x_q    <= '0;
            col_y_q    <= '0;
            cue_pend_q <= 1'b0;
            cue_id_q   <= '0;
            cue_x_q    <= '0;
            cue_y_q    <= '0;
            wall_x_q   <= '0;
            wall_y_q   <= '0;
            hold_q     <= '0;
            fric_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            stopped_q  <= stopped_d;
            dropped_q  <= dropped_d;
            col_seen_q <= col_seen_d;
            col_pend_q <= col_pend_d;
            col_id_q   <= col_id_d;
            col_x_q    <= col_x_d;
            col_y_q    <= col_y_d;
            cue_pend_q <= cue_pend_d;
            cue_id_q   <= cue_id_d;
            cue_x_q    <= cue_x_d;
            cue_y_q    <= cue_y_d;
            wall_x_q   <= wall_x_d;
            wall_y_q   <= wall_y_d;
            hold_q     <= hold_d;
            fric_q     <= fric_d;
        end
    end

    assign Xspeed_VEC_out    = x_q;
    assign Yspeed_VEC_out    = y_q;
    assign all_stopped       = stopped_q;
    assign collision_dropped = dropped_q;
endmodule

// File: tb/tb_balls_speed_register.sv
// Bench for balls_speed_register: table of wall/saturation cases plus hand-written frame sequences.
`timescale 1ns/1ps
module tb_balls_speed_register;
    import balls_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 startOfFrame;
    logic                 collide_valid;
    ball_id_t [1:0]       col_id;
    speed_vec_t           Xspeed_calc_in;
    speed_vec_t           Yspeed_calc_in;
    logic                 cue_valid;
    ball_id_t             cue_id;
    speed_t               cue_Xspeed;
    speed_t               cue_Yspeed;
    logic [NUM_BALLS-1:0] wall_bounce_x;
    logic [NUM_BALLS-1:0] wall_bounce_y;
    speed_vec_t           Xspeed_VEC_out;
    speed_vec_t           Yspeed_VEC_out;
    logic                 all_stopped;
    logic                 collision_dropped;

    always #5 clk = ~clk;

    balls_speed_register dut (
        .clk              (clk),
        .reset            (reset),
        .startOfFrame     (startOfFrame),
        .collide_valid    (collide_valid),
        .col_id           (col_id),
        .Xspeed_calc_in   (Xspeed_calc_in),
        .Yspeed_calc_in   (Yspeed_calc_in),
        .cue_valid        (cue_valid),
        .cue_id           (cue_id),
        .cue_Xspeed       (cue_Xspeed),
        .cue_Yspeed       (cue_Yspeed),
        .wall_bounce_x    (wall_bounce_x),
        .wall_bounce_y    (wall_bounce_y),
        .Xspeed_VEC_out   (Xspeed_VEC_out),
        .Yspeed_VEC_out   (Yspeed_VEC_out),
        .all_stopped      (all_stopped),
        .collision_dropped(collision_dropped)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int    ball;
        int    ex;
        int    ey;
        string tag;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int cx; int cy; int px; int py; int ex; int ey; int es;
    } wall_vec_t;
    wall_vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string tag, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic sb_push(input string tag, input int b, input int ex, input int ey);
        exp_t e;
        e.ball = b; e.ex = ex; e.ey = ey; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_int($sformatf("%s.b%0d.x", e.tag, e.ball), int'($signed(Xspeed_VEC_out[e.ball])), e.ex);
            check_int($sformatf("%s.b%0d.y", e.tag, e.ball), int'($signed(Yspeed_VEC_out[e.ball])), e.ey);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_cue(input int id, input int x, input int y);
        cue_valid = 1'b1; cue_id = ball_id_t'(id);
        cue_Xspeed = speed_t'(x); cue_Yspeed = speed_t'(y);
        tick();
        cue_valid = 1'b0;
    endtask

    task automatic set_col(input int a, input int b, input int xa, input int ya, input int xb, input int yb);
        col_id[0] = ball_id_t'(a);
        col_id[1] = ball_id_t'(b);
        for (int i = 0; i < NUM_BALLS; i++) begin
            Xspeed_calc_in[i] = speed_t'(99);
            Yspeed_calc_in[i] = speed_t'(99);
        end
        Xspeed_calc_in[a] = speed_t'(xa); Yspeed_calc_in[a] = speed_t'(ya);
        Xspeed_calc_in[b] = speed_t'(xb); Yspeed_calc_in[b] = speed_t'(yb);
        collide_valid = 1'b1;
    endtask

    // startOfFrame pulse then the APPLY and FRICTION cycles; noisy drives events that must be ignored.
    task automatic frame(input bit noisy);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0; cue_valid = 1'b0; collide_valid = 1'b0;
        wall_bounce_x = '0; wall_bounce_y = '0;
        if (noisy) begin
            startOfFrame = 1'b1; cue_valid = 1'b1; cue_id = 4'd2;
            cue_Xspeed = speed_t'(9); cue_Yspeed = speed_t'(9);
        end
        tick();
        tick();
        startOfFrame = 1'b0; cue_valid = 1'b0;
    endtask

    initial begin
        int drops;
        reset = 1'b1; startOfFrame = 1'b0; collide_valid = 1'b0; col_id = '0;
        Xspeed_calc_in = '0; Yspeed_calc_in = '0; cue_valid = 1'b0; cue_id = '0;
        cue_Xspeed = '0; cue_Yspeed = '0; wall_bounce_x = '0; wall_bounce_y = '0;

        tbl[0] = '{-1024,     0, 1, 0,  511,   0, 0};
        tbl[1] = '{    3,     0, 2, 0,   -3,   0, 0};
        tbl[2] = '{  600,    -7, 0, 1,  511,   7, 0};
        tbl[3] = '{ -600,    20, 1, 1,  511, -20, 0};
        tbl[4] = '{  511, -1024, 1, 1, -511, 511, 0};
        tbl[5] = '{   -1,     1, 0, 0,   -1,   1, 0};
        tbl[6] = '{    0,     0, 1, 1,    0,   0, 1};

        // Reset state and idle frames.
        tick(); tick();
        reset = 1'b0;
        for (int b = 0; b < NUM_BALLS; b++) sb_push("reset", b, 0, 0);
        sb_drain();
        check_int("reset.all_stopped", int'(all_stopped), 1);
        check_int("reset.dropped", int'(collision_dropped), 0);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < NUM_BALLS; b++) sb_push($sformatf("idle%0d", f), b, 0, 0);
            frame(1'b0);
            sb_drain();
            check_int($sformatf("idle%0d.all_stopped", f), int'(all_stopped), 1);
        end

        // Wall bounce / saturation table on ball 2.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            drive_cue(2, tbl[i].cx, tbl[i].cy);
            frame(1'b0);
            for (int p = 0; p < 2; p++) begin
                wall_bounce_x[2] = (p < tbl[i].px);
                wall_bounce_y[2] = (p < tbl[i].py);
                tick();
                wall_bounce_x = '0; wall_bounce_y = '0;
                tick();
            end
            sb_push($sformatf("wall%0d", i), 2, tbl[i].ex, tbl[i].ey);
            sb_push($sformatf("wall%0d", i), 0, 0, 0);
            frame(1'b0);
            sb_drain();
            check_int($sformatf("wall%0d.all_stopped", i), int'(all_stopped), tbl[i].es);
        end

        // Cue coinciding with startOfFrame, commit timing, then friction on the 8th frame.
        do_reset();
        cue_valid = 1'b1; cue_id = 4'd1; cue_Xspeed = speed_t'(100); cue_Yspeed = speed_t'(-40);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0; cue_valid = 1'b0;
        check_int("cue.pre_apply.x", int'($signed(Xspeed_VEC_out[1])), 0);
        tick();
        sb_push("cue.apply", 1, 100, -40);
        sb_drain();
        tick();
        check_int("cue.all_stopped", int'(all_stopped), 0);
        for (int f = 2; f <= 8; f++) begin
            frame(f < 8);
            if (f == 7) begin
                sb_push("fric.f7", 1, 100, -40);
                sb_push("fric.f7", 2, 0, 0);
                sb_drain();
            end
        end
        sb_push("fric.f8", 1, 99, -39);
        sb_push("fric.f8", 2, 0, 0);
        sb_drain();

        // Cue beats collision on ball 0; ball 1 holdoff blocks the pair for exactly 3 more frames.
        do_reset();
        drive_cue(0, 30, -20);
        set_col(0, 1, 5, 5, 7, -3);
        tick();
        collide_valid = 1'b0;
        sb_push("cuecol", 0, 30, -20);
        sb_push("cuecol", 1, 7, -3);
        sb_push("cuecol", 2, 0, 0);
        frame(1'b0);
        sb_drain();
        for (int f = 0; f < 4; f++) begin
            set_col(0, 1, 50, 50, 60, 60);
            tick();
            collide_valid = 1'b0;
            if (f < 3) begin
                sb_push($sformatf("holdoff%0d", f), 0, 30, -20);
                sb_push($sformatf("holdoff%0d", f), 1, 7, -3);
            end else begin
                sb_push("holdoff_expired", 0, 50, 50);
                sb_push("holdoff_expired", 1, 60, 60);
            end
            frame(1'b0);
            sb_drain();
        end

        // Second distinct pair in one frame is dropped; repeating the first pair is silent.
        do_reset();
        drops = 0;
        set_col(0, 1, 5, 5, 7, -3);
        tick(); drops += int'(collision_dropped);
        tick(); drops += int'(collision_dropped);
        set_col(0, 2, 40, 40, 41, 41);
        tick();
        check_int("drop.timing", int'(collision_dropped), 1);
        drops += int'(collision_dropped);
        collide_valid = 1'b0;
        tick(); drops += int'(collision_dropped);
        tick(); drops += int'(collision_dropped);
        check_int("drop.pulses", drops, 1);
        sb_push("drop", 0, 5, 5);
        sb_push("drop", 1, 7, -3);
        sb_push("drop", 2, 0, 0);
        frame(1'b0);
        sb_drain();

        // Reset during APPLY discards the pending cue and returns to COLLECT.
        do_reset();
        drive_cue(0, 50, 0);
        sb_push("rst.pre", 0, 50, 0);
        frame(1'b0);
        sb_drain();
        cue_valid = 1'b1; cue_id = 4'd0; cue_Xspeed = speed_t'(80); cue_Yspeed = speed_t'(9);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0; cue_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_push("rst.mid", 0, 0, 0);
        sb_drain();
        check_int("rst.mid.all_stopped", int'(all_stopped), 1);
        for (int b = 0; b < NUM_BALLS; b++) sb_push("rst.next", b, 0, 0);
        frame(1'b0);
        sb_drain();
        check_int("rst.next.all_stopped", int'(all_stopped), 1);
        drive_cue(2, 4, 4);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        sb_push("rst.collect", 2, 4, 4);
        sb_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/balls_speed_register.md
Name: balls_speed_register

Overview:
Per-ball velocity state holder that sits directly downstream of the ball-pair speed calculator. It owns the authoritative X/Y speed of every ball and captures the calculator's combinational post-collision speeds during the frame. It commits cue strikes, collisions, wall bounces and rolling friction once per frame on startOfFrame. Its registered outputs feed back into the calculator's speed inputs and into the per-ball position movers.

Parameters:
NUM_BALLS, 3, number of balls; ball IDs are 0..NUM_BALLS-1.
SPEED_W, 11, signed speed width in two's complement.
MAX_SPEED, 511, saturation magnitude applied to every committed speed component.
FRICTION_PERIOD, 8, frames between friction decrements (range 1..255).
FRICTION_STEP, 1, magnitude removed from each nonzero component per friction event.
HOLDOFF_FRAMES, 4, frames during which a ball that just collided ignores further collisions.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at frame start
collide_valid  in  1  calculator's pair-valid condition: both IDs flagged and IDs differ
col_id  in  2x4  colliding pair; [0] lower ID, [1] higher ID
Xspeed_calc_in  in  NUM_BALLSxSPEED_W  calculator X outputs; meaningful only at the two col_id entries
Yspeed_calc_in  in  NUM_BALLSxSPEED_W  calculator Y outputs
cue_valid  in  1  cue strike request, one-cycle pulse
cue_id  in  4  struck ball
cue_Xspeed, cue_Yspeed  in  SPEED_W each  strike velocity
wall_bounce_x  in  NUM_BALLS  per-ball flag: negate X speed
wall_bounce_y  in  NUM_BALLS  per-ball flag: negate Y speed
Xspeed_VEC_out  out  NUM_BALLSxSPEED_W  registered X speeds
Yspeed_VEC_out  out  NUM_BALLSxSPEED_W  registered Y speeds
all_stopped  out  1  registered; high when every speed component is 0
collision_dropped  out  1  one-cycle pulse when a second pair in one frame is discarded

Behaviour:
- Reset: all speeds 0, all_stopped=1, collision_dropped=0, pending flags cleared, holdoff counters 0, friction counter 0, FSM=COLLECT.
- FSM states:
  - COLLECT: capture pending events during the frame.
  - APPLY: one cycle, commit latched events.
  - FRICTION: one cycle, commit friction.
  - Transitions: COLLECT -startOfFrame-> APPLY -> FRICTION -> COLLECT.
- Outputs change only on APPLY and FRICTION cycles. New speeds are visible 1 cycle after the startOfFrame cycle and final 2 cycles after it.
- COLLECT, collision capture:
  - First cycle with collide_valid=1 latches col_id and the calculator speeds at both IDs.
  - The capture is accepted only if both balls have holdoff=0 and both IDs are < NUM_BALLS.
  - A later valid pair in the same frame with a different col_id is discarded and pulses collision_dropped. The same pair re-asserting is silently ignored.
- COLLECT, cue capture: the last cue_valid in the frame wins. cue_id >= NUM_BALLS is ignored.
- COLLECT, wall capture: wall_bounce_x/y flags are ORed into sticky per-ball pending bits.
- startOfFrame coinciding with collide_valid or cue_valid: the event belongs to the closing frame and is applied in this APPLY.
- APPLY, per-ball priority:
  - Cue: the struck ball takes the cue speeds.
  - Collision: otherwise, a ball in the latched pair takes the latched speeds and its holdoff is set to HOLDOFF_FRAMES.
  - Wall bounce: otherwise, pending wall bits negate the corresponding component.
  - Otherwise the speed is held.
  - All pending state is cleared.
- Arithmetic and width rules:
  - Negation of -2^(SPEED_W-1) yields +MAX_SPEED.
  - Every committed value is saturated to ±MAX_SPEED.
- FRICTION:
  - Holdoff counters of nonzero value decrement by 1.
  - The friction counter increments. When it reaches FRICTION_PERIOD-1 it wraps to 0, and each component moves toward 0 by FRICTION_STEP, clamped at 0 with no sign flip.
  - all_stopped is recomputed from the post-friction values.
- startOfFrame while in APPLY or FRICTION is ignored, and no events are captured in those two cycles.
- Reset asserted mid-frame or mid-APPLY returns everything to reset values on the next edge; latched events are lost.

Decomposition:
- Shared package (balls_pkg): NUM_BALLS, SPEED_W, ball_id_t (4-bit), speed_t (signed SPEED_W), the speed vector typedef, and the FSM state enum, so the calculator and position movers use identical types.
- One sub-module: speed_sat_decay. It is a combinational per-component helper that performs the negate, saturate and toward-zero decrement steps, instantiated 2×NUM_BALLS times.

Test Plan:
- Reset, then 3 frames idle -> all speeds 0, all_stopped=1, and no change on any startOfFrame.
- cue_valid with id=1 and speed (+100,-40), then startOfFrame -> ball1 reads (100,-40) one cycle later and all_stopped=0. After 8 frames, with FRICTION_PERIOD=8 and STEP=1, it reads (99,-39).
- Same cycle as a pending collision on pair (0,1): cue on ball0 plus collision latched with ball0=(5,5), ball1=(7,-3) -> after APPLY, ball0 holds the cue value, ball1=(7,-3), and ball1 holdoff=4.
- Collision pair (0,1) applied, then pair (0,1) valid again in the next 3 frames -> no speed change. A valid pair (0,2) in the same frame as the first -> ball0 and ball2 unchanged and collision_dropped pulses once.
- Ball2 at X=-1024 with wall_bounce_x[2] -> X=+511 (saturated). Ball2 at X=+3 with wall_bounce_x[2] pulsed twice in one frame -> X=-3 (sticky bit, single negate).
- reset asserted in the cycle after startOfFrame while ball0=(50,0) -> next edge gives all zeros, FSM back in COLLECT, and the next startOfFrame applies nothing.
